// File: rtl/ahb_apb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_apb_arbiter_if
//
// Purpose: groups the request/grant signals between the AHB requesters and
// the round-robin arbiter that sits in front of the AHB-to-APB bridge.
//
// Signals:
//   Hbusreq   [NUM_MASTERS] per-master bus request
//   Hlock     [NUM_MASTERS] per-master lock request
//   Htrans    [2]           transfer type of the current address-phase owner
//   Hready    [1]           transfer-complete indication from the bridge
//   Hgrant    [NUM_MASTERS] one-hot grant
//   Hmaster   [MIDX_W]      address-phase owner index
//   Hmastlock [1]           current address phase is locked
//
// Modports:
//   master : requester / bridge side; drives requests, Htrans and Hready,
//            observes the grant outputs.
//   slave  : arbiter side; observes requests, drives the grant outputs.
// ---------------------------------------------------------------------------
interface ahb_apb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 2
);
  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic                   Hready;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MIDX_W-1:0]      Hmaster;
  logic                   Hmastlock;

  modport master (
    output Hbusreq,
    output Hlock,
    output Htrans,
    output Hready,
    input  Hgrant,
    input  Hmaster,
    input  Hmastlock
  );

  modport slave (
    input  Hbusreq,
    input  Hlock,
    input  Htrans,
    input  Hready,
    output Hgrant,
    output Hmaster,
    output Hmastlock
  );
endinterface

// File: rtl/ahb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_apb_arbiter
//
// Purpose: round-robin AHB master arbiter in front of the AHB-to-APB bridge
// slave port. Produces a registered one-hot grant, the registered
// address-phase owner index (Hmaster) and a registered master-lock flag.
// Re-arbitration happens only on Hready=1 cycles; a tenure is capped at
// MAX_BEATS accepted transfers while another master is waiting.
//
// Parameters:
//   NUM_MASTERS  number of requesters, 2..8
//   MIDX_W       width of the master index, ceil(log2(NUM_MASTERS))
//   MAX_BEATS    accepted transfers per tenure before forced hand-over, 1..255
//
// Ports:
//   Hclk    clock, all registers on the rising edge
//   Hreset  asynchronous active-high reset
//   bus     ahb_apb_arbiter_if.slave (Hbusreq, Hlock, Htrans, Hready in;
//           Hgrant, Hmaster, Hmastlock out)
//
// Build option:
//   ARB_LOCK_EN  when defined, enables the ST_LOCKED state and a live
//                Hmastlock; otherwise Hlock is ignored and Hmastlock is 0.
// ---------------------------------------------------------------------------
module ahb_apb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = 2,
  parameter int MAX_BEATS   = 16
) (
  input logic                Hclk,
  input logic                Hreset,
  ahb_apb_arbiter_if.slave   bus
);

  localparam int                 BEAT_W   = 8;
  localparam logic [BEAT_W-1:0]  BEAT_CAP = BEAT_W'(MAX_BEATS);
  localparam logic [MIDX_W-1:0]  LAST_RST = MIDX_W'(NUM_MASTERS - 1);

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWN    = 2'd1
  } state_t;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                 state_q,     state_d;
  logic [NUM_MASTERS-1:0] grant_q,     grant_d;
  logic [MIDX_W-1:0]      grant_idx_q, grant_idx_d;  // index of grant_q
  logic [MIDX_W-1:0]      last_q,      last_d;       // round-robin pointer
  logic [BEAT_W-1:0]      beat_q,      beat_d;
  logic [MIDX_W-1:0]      hmaster_q,   hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  // -------------------------------------------------------------------------
  // Winner scan: indices last+1, last+2, ... modulo NUM_MASTERS. The loop
  // runs from the farthest offset down to the nearest so that the nearest
  // requester overwrites the rest. Offset NUM_MASTERS is last itself, which
  // puts the current owner at the very end of the scan.
  // -------------------------------------------------------------------------
  logic              win_found;
  logic [MIDX_W-1:0] win_idx;
  int                cand;

  always_comb begin : p_scan
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = (int'(last_q) + i) % NUM_MASTERS;
      if (bus.Hbusreq[MIDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = MIDX_W'(cand);
      end
    end
  end

  // One-hot decode of the winner and the "someone else wants the bus" mask.
  logic [NUM_MASTERS-1:0] win_onehot;
  logic [NUM_MASTERS-1:0] other_req_vec;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign win_onehot[gi]    = (win_idx == MIDX_W'(gi));
      assign other_req_vec[gi] = bus.Hbusreq[gi] & ~grant_q[gi];
    end
  endgenerate

  logic owner_req;
  logic others_req;
  logic cap_hit;

  assign owner_req  = bus.Hbusreq[grant_idx_q];
  assign others_req = |other_req_vec;
  assign cap_hit    = (beat_q == BEAT_CAP);

`ifdef ARB_LOCK_EN
  logic owner_lock;
  assign owner_lock = bus.Hlock[grant_idx_q];
  logic unused_sig;
  assign unused_sig = bus.Htrans[0];
`else
  // Hlock is part of the port list but has no function in this build.
  logic unused_sig;
  assign unused_sig = ^{bus.Hlock, bus.Htrans[0]};
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic. Nothing moves while Hready is low.
  // -------------------------------------------------------------------------
  logic arb;

  always_comb begin : p_next
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_d      = last_q;
    beat_d      = beat_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    arb         = 1'b0;

    if (bus.Hready) begin
      // Accepted NONSEQ/SEQ beats of the current tenure, saturating.
      if (bus.Htrans[1] && !cap_hit) begin
        beat_d = beat_q + 1'b1;
      end

      // The address phase follows the grant by one accepted transfer.
      hmaster_d = grant_idx_q;
`ifdef ARB_LOCK_EN
      hmastlock_d = owner_lock;
`else
      hmastlock_d = 1'b0;
`endif

      case (state_q)
        ST_PARK: begin
          arb = 1'b1;
        end
        ST_OWN: begin
`ifdef ARB_LOCK_EN
          // A lock request from an active owner wins over the beat cap.
          if (owner_req && owner_lock) begin
            state_d = ST_LOCKED;
          end else begin
            arb = !owner_req || (cap_hit && others_req);
          end
`else
          arb = !owner_req || (cap_hit && others_req);
`endif
        end
`ifdef ARB_LOCK_EN
        ST_LOCKED: begin
          // No hand-over of any kind until the owner lets go; the release
          // cycle itself performs a normal arbitration.
          arb = !owner_req || !owner_lock;
        end
`endif
        default: begin
          arb = 1'b1;
        end
      endcase

      if (arb) begin
        if (win_found) begin
          grant_d     = win_onehot;
          grant_idx_d = win_idx;
          last_d      = win_idx;
          state_d     = ST_OWN;
          if (win_idx != grant_idx_q) begin
            beat_d = '0;
          end
        end else begin
          // Park on master 0; the round-robin pointer keeps its position.
          grant_d     = NUM_MASTERS'(1);
          grant_idx_d = '0;
          state_d     = ST_PARK;
          if (grant_idx_q != '0) begin
            beat_d = '0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Hclk or posedge Hreset) begin : p_regs
    if (Hreset) begin
      state_q     <= ST_PARK;
      grant_q     <= NUM_MASTERS'(1);
      grant_idx_q <= '0;
      last_q      <= LAST_RST;
      beat_q      <= '0;
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.Hgrant    = grant_q;
  assign bus.Hmaster   = hmaster_q;
  assign bus.Hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_arbiter
//
// Directed bench for ahb_apb_arbiter with NUM_MASTERS=4, MAX_BEATS=4.
// Inputs change 1 time unit after the rising edge and outputs are checked
// at the same point. Works with and without ARB_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_ahb_apb_arbiter;

  logic Hclk;
  logic Hreset;
  int   errors;
  int   checks;

  ahb_apb_arbiter_if #(.NUM_MASTERS(4), .MIDX_W(2)) bus ();

  ahb_apb_arbiter #(
    .NUM_MASTERS (4),
    .MIDX_W      (2),
    .MAX_BEATS   (4)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.Hbusreq = 4'b0000;
    bus.Hlock   = 4'b0000;
    bus.Htrans  = 2'b00;
    bus.Hready  = 1'b1;
    Hreset      = 1'b1;

    // Reset values
    tick();
    tick();
    chk("rst_grant",  32'(bus.Hgrant),    32'h1);
    chk("rst_master", 32'(bus.Hmaster),   32'h0);
    chk("rst_lock",   32'(bus.Hmastlock), 32'h0);
    chk("rst_beat",   32'(dut.beat_q),    32'h0);
    Hreset = 1'b0;

    // Idle: parked on master 0
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_grant",  32'(bus.Hgrant),    32'h1);
      chk("idle_master", 32'(bus.Hmaster),   32'h0);
      chk("idle_lock",   32'(bus.Hmastlock), 32'h0);
    end

    // Masters 1 and 2 request together: 1 first, then 2 after 1 drops
    bus.Hbusreq = 4'b0110;
    tick();
    chk("rr_grant1",   32'(bus.Hgrant),  32'h2);
    chk("rr_mst_lag",  32'(bus.Hmaster), 32'h0);
    tick();
    chk("rr_hold1",    32'(bus.Hgrant),  32'h2);
    chk("rr_master1",  32'(bus.Hmaster), 32'h1);
    bus.Hbusreq = 4'b0100;
    tick();
    chk("rr_grant2",   32'(bus.Hgrant),  32'h4);
    chk("rr_mst_lag2", 32'(bus.Hmaster), 32'h1);
    tick();
    chk("rr_hold2",    32'(bus.Hgrant),  32'h4);
    chk("rr_master2",  32'(bus.Hmaster), 32'h2);

    // Fairness cap: master 2 streams, counter saturates, master 0 then wins
    bus.Htrans = 2'b10;
    tick();
    chk("cap_beat1", 32'(dut.beat_q), 32'h1);
    bus.Htrans = 2'b11;
    tick();
    chk("cap_beat2", 32'(dut.beat_q), 32'h2);
    tick();
    chk("cap_beat3", 32'(dut.beat_q), 32'h3);
    tick();
    chk("cap_beat4", 32'(dut.beat_q), 32'h4);
    chk("cap_grant", 32'(bus.Hgrant), 32'h4);
    tick();
    chk("cap_sat",   32'(dut.beat_q), 32'h4);
    chk("cap_alone", 32'(bus.Hgrant), 32'h4);
    bus.Hbusreq = 4'b0101;
    tick();
    chk("cap_switch", 32'(bus.Hgrant),  32'h1);
    chk("cap_clear",  32'(dut.beat_q),  32'h0);
    chk("cap_master", 32'(bus.Hmaster), 32'h2);

    // Hready stall: master 0 drops, master 3 requests while the bridge waits
    bus.Htrans  = 2'b11;
    bus.Hready  = 1'b0;
    bus.Hbusreq = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_grant",  32'(bus.Hgrant),  32'h1);
      chk("stall_master", 32'(bus.Hmaster), 32'h2);
      chk("stall_beat",   32'(dut.beat_q),  32'h0);
    end
    bus.Hready = 1'b1;
    bus.Htrans = 2'b00;
    tick();
    chk("stall_grant3", 32'(bus.Hgrant),  32'h8);
    chk("stall_mst0",   32'(bus.Hmaster), 32'h0);
    tick();
    chk("own_master3",  32'(bus.Hmaster), 32'h3);

    // Asynchronous reset in the middle of master 3's tenure
    bus.Htrans = 2'b11;
    tick();
    tick();
    chk("m3_beat2", 32'(dut.beat_q), 32'h2);
    #2;
    Hreset = 1'b1;
    #1;
    chk("arst_grant",  32'(bus.Hgrant),    32'h1);
    chk("arst_master", 32'(bus.Hmaster),   32'h0);
    chk("arst_lock",   32'(bus.Hmastlock), 32'h0);
    chk("arst_beat",   32'(dut.beat_q),    32'h0);
    bus.Hbusreq = 4'b1010;
    bus.Htrans  = 2'b00;
    #1;
    Hreset = 1'b0;
    tick();
    chk("post_rst_grant", 32'(bus.Hgrant), 32'h2);

    // Nobody requests: park on master 0
    bus.Hbusreq = 4'b0000;
    tick();
    chk("park_grant",  32'(bus.Hgrant),  32'h1);
    chk("park_master", 32'(bus.Hmaster), 32'h1);

    // Master 1 with Hlock, master 2 waiting
    bus.Hbusreq = 4'b0010;
    bus.Hlock   = 4'b0010;
    tick();
    chk("lk_grant1", 32'(bus.Hgrant), 32'h2);
    tick();
    bus.Hbusreq = 4'b0110;
    bus.Htrans  = 2'b11;
`ifdef ARB_LOCK_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lk_hold",     32'(bus.Hgrant),    32'h2);
      chk("lk_mastlock", 32'(bus.Hmastlock), 32'h1);
    end
    bus.Hlock = 4'b0000;
    tick();
    chk("lk_release",  32'(bus.Hgrant),    32'h4);
    chk("lk_unlocked", 32'(bus.Hmastlock), 32'h0);
`else
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("nolk_hold",  32'(bus.Hgrant),    32'h2);
      chk("nolk_beat",  32'(dut.beat_q),    32'(i));
      chk("nolk_mlock", 32'(bus.Hmastlock), 32'h0);
    end
    tick();
    chk("nolk_cap",   32'(bus.Hgrant),    32'h4);
    chk("nolk_mlock", 32'(bus.Hmastlock), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_apb_arbiter.md
# ahb_apb_arbiter

Round-robin AHB master arbiter placed in front of the AHB-to-APB bridge slave port, so that up to NUM_MASTERS AHB requesters can share a single bridge and its APB peripheral set. It produces registered one-hot grants, the address-phase owner index used by the bridge-side address/data/control muxes, and a master-lock indication. It applies a beat-count fairness cap, and only re-arbitrates on bridge-ready (Hready) cycles.

## Interface
- NUM_MASTERS, 4, number of requesters; legal range 2..8.
- MIDX_W, 2, width of the master index; must equal ceil(log2(NUM_MASTERS)).
- MAX_BEATS, 16, accepted transfers per tenure before a forced hand-over while others wait; legal range 1..255.
- Hclk  in  1  single clock; every register is clocked on its rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Hbusreq  in  NUM_MASTERS  per-master bus request.
- Hlock  in  NUM_MASTERS  per-master lock request; used only when ARB_LOCK_EN is defined.
- Htrans  in  2  transfer type of the current address-phase owner, already muxed: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hready  in  1  transfer-complete indication from the bridge Hreadyout.
- Hgrant  out  NUM_MASTERS  one-hot grant, registered.
- Hmaster  out  MIDX_W  address-phase owner index, registered.
- Hmastlock  out  1  current address phase is locked, registered.

## Operation
- Reset values:
  - Hgrant = 1 (master 0 parked); Hmaster = 0; Hmastlock = 0.
  - State = ST_PARK; beat counter = 0; round-robin pointer last = NUM_MASTERS-1.
- States:
  - ST_PARK: no request is pending; grant is parked on master 0.
  - ST_OWN: the granted master is actively requesting.
  - ST_LOCKED: lock held; exists only with ARB_LOCK_EN.
- Arbitration cycle: a cycle with Hready=1 and any of the following. With Hready=0, every register holds.
  - state is ST_PARK;
  - the owner's Hbusreq = 0;
  - beat count = MAX_BEATS and another master is requesting.
- Winner selection:
  - Scan indices last+1, last+2, … modulo NUM_MASTERS; the first with Hbusreq=1 wins.
  - The owner is included last, so it is re-granted only if no other master requests.
  - If no master requests: Hgrant = master 0 and next state = ST_PARK.
  - Otherwise: Hgrant = winner, last = winner, next state = ST_OWN.
- Beat counter:
  - Increments on each cycle with Hready=1 and Htrans[1]=1; saturates at MAX_BEATS.
  - Clears to 0 when the grant changes to a different master.
- Hmaster is loaded with the granted index on any edge where Hready=1.
- Simultaneous requests from ST_PARK right after reset resolve to master 0, then 1, 2, … in round-robin order.
- A request deasserted during the same cycle its grant lands: the arbiter re-arbitrates at the next Hready=1 cycle; no bus is lost beyond that one cycle.

## Timing
- Grant latency: Hbusreq asserted in cycle n (n is an arbitration cycle) gives Hgrant visible in cycle n+1.
- Hmaster and Hmastlock update at the first rising edge after the grant with Hready=1, giving one address phase of lag.
- Hready low for k cycles stalls Hgrant, Hmaster and the beat count for exactly k cycles.
- Asynchronous reset mid-tenure: outputs return to reset values immediately, independent of Hclk.
- The fairness hand-over takes effect at the first arbitration cycle after the cap is reached; Htrans of that cycle is not inspected.

## Configuration
- ARB_LOCK_EN defined:
  - In ST_OWN, if the owner has Hlock=1 and Hbusreq=1 on an arbitration cycle, the next state is ST_LOCKED.
  - ST_LOCKED suppresses all re-arbitration, including the MAX_BEATS cap.
  - ST_LOCKED exits only when the owner drops Hlock or Hbusreq on a cycle with Hready=1.
  - Hmastlock <= Hlock[granted index] on edges with Hready=1.
- ARB_LOCK_EN undefined:
  - The Hlock port is present but ignored.
  - Hmastlock is constant 0.
  - ST_LOCKED is not implemented.

## Test plan
- Reset, then Hbusreq=0000 for 5 cycles -> Hgrant=0001, Hmaster=0, Hmastlock=0 throughout.
- Hbusreq=0110 in one cycle with Hready=1 -> Hgrant=0010 next cycle. Master 1 then drops its request -> Hgrant=0100, and Hmaster follows one Hready edge later.
- Master 2 alone streaming SEQ with MAX_BEATS=4, then master 0 requests -> after the 4th accepted beat, Hgrant=0001; beat counter reads 0 after the switch.
- Hready held 0 for 3 cycles while master 3 raises Hbusreq -> Hgrant unchanged for 3 cycles, and becomes 1000 on the cycle after Hready returns to 1.
- ARB_LOCK_EN: master 1 holds Hlock=1 for 20 beats with master 2 requesting -> Hgrant stays 0010 and Hmastlock=1. Hlock drops -> Hgrant=0100 next arbitration cycle and Hmastlock=0.
- Hreset pulsed mid-tenure of master 3 -> Hgrant=0001 and Hmaster=0 without a clock edge; afterwards the first grant goes to the lowest requesting index.
